// File: rtl/cvt_int_seq.sv
// Final float-to-integer step: rounds, negates and saturates the normalized magnitude
// using one 32-bit adder slice over one (32-bit target) or two (64-bit target) passes.
module cvt_int_seq #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            InValid,
   output logic            InReady,
   input  logic            Signed,
   input  logic            Int64,
   input  logic            Plus1,
   input  logic            Xs,
   input  logic            NaN,
   input  logic            MagOvf,
   input  logic [XLEN-1:0] Mag,
   input  logic            Flush,
   output logic            OutValid,
   input  logic            OutReady,
   output logic [XLEN-1:0] Res,
   output logic            NV
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t state, state_next;

   logic            signed_q, w64_q, plus1_q, xs_q, nan_q, magovf_q;
   logic [63:0]     mag_q;
   logic [31:0]     sum_lo_q;
   logic            carry_q;
   logic [XLEN-1:0] res_q;
   logic            nv_q;

   logic            accept, finish;
   logic [31:0]     add_a;
   logic            add_cin;
   logic [32:0]     add_out;
   logic [63:0]     sum_w, sat_max, sat_min, res_next;
   logic            big, in_range, nv_next;

   assign accept   = (state == IDLE) && InValid && !Flush;
   assign finish   = ((state == LO && !w64_q) || state == HI) && !Flush;
   assign InReady  = (state == IDLE);
   assign OutValid = (state == DONE);
   assign Res      = res_q;
   assign NV       = nv_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (InValid) state_next = LO;
         LO:      state_next = w64_q ? HI : DONE;
         HI:      state_next = DONE;
         DONE:    if (OutReady) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (Flush) state_next = IDLE;
   end

   // Shared slice: low half in LO with the rounding carry-in, high half in HI with the stored carry.
   always_comb begin
      add_a   = mag_q[31:0] ^ {32{xs_q}};
      add_cin = plus1_q ^ xs_q;
      if (state == HI) begin
         add_a   = mag_q[63:32] ^ {32{xs_q}};
         add_cin = carry_q;
      end
      add_out = {1'b0, add_a} + {32'b0, add_cin};
   end

   // For Xs=1 the carry-out is set only when the rounded magnitude is zero.
   always_comb begin
      sum_w = {add_out[31:0], sum_lo_q};
      big   = magovf_q;
      if (!w64_q) begin
         sum_w = {{32{add_out[31]}}, add_out[31:0]};
         big   = magovf_q || (|mag_q[63:32]);
      end

      if (xs_q) begin
         in_range = !big && (add_out[32] || (signed_q && add_out[31]));
      end else begin
         in_range = !big && !add_out[32] && !(signed_q && add_out[31]);
      end

      if (w64_q) begin
         sat_max = signed_q ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
         sat_min = signed_q ? 64'h8000_0000_0000_0000 : 64'h0;
      end else begin
         sat_max = signed_q ? 64'h0000_0000_7FFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
         sat_min = signed_q ? 64'hFFFF_FFFF_8000_0000 : 64'h0;
      end

      res_next = sat_max;
      nv_next  = 1'b1;
      if (!nan_q) begin
         if (in_range) begin
            res_next = sum_w;
            nv_next  = 1'b0;
         end else if (xs_q) begin
            res_next = sat_min;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         signed_q <= 1'b0;
         w64_q    <= 1'b0;
         plus1_q  <= 1'b0;
         xs_q     <= 1'b0;
         nan_q    <= 1'b0;
         magovf_q <= 1'b0;
         mag_q    <= '0;
         sum_lo_q <= '0;
         carry_q  <= 1'b0;
         res_q    <= '0;
         nv_q     <= 1'b0;
      end else begin
         if (accept) begin
            signed_q <= Signed;
            w64_q    <= (XLEN == 64) && Int64;
            plus1_q  <= Plus1;
            xs_q     <= Xs;
            nan_q    <= NaN;
            magovf_q <= MagOvf;
            mag_q    <= 64'(Mag);
         end
         if (state == LO && !Flush) begin
            sum_lo_q <= add_out[31:0];
            carry_q  <= add_out[32];
         end
         if (finish) begin
            res_q <= res_next[XLEN-1:0];
            nv_q  <= nv_next;
         end
      end
   end

endmodule

// File: tb/tb_cvt_int_seq.sv
// Self-checking bench for cvt_int_seq: directed corner cases plus randomized
// conversions compared against an arithmetic range model.
module tb_cvt_int_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic        sgn, int64, plus1, xs, nan, mag_ovf;
   logic [63:0] mag;
   logic        flush;
   logic        out_valid, out_ready;
   logic [63:0] res;
   logic        nv;

   int check_count = 0;
   int fail_count  = 0;

   cvt_int_seq #(.XLEN(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .InValid  (in_valid),
      .InReady  (in_ready),
      .Signed   (sgn),
      .Int64    (int64),
      .Plus1    (plus1),
      .Xs       (xs),
      .NaN      (nan),
      .MagOvf   (mag_ovf),
      .Mag      (mag),
      .Flush    (flush),
      .OutValid (out_valid),
      .OutReady (out_ready),
      .Res      (res),
      .NV       (nv)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
      end
   endtask

   // Truncate to the target width and sign-extend a 32-bit result to 64 bits.
   function automatic logic [63:0] fitWidth(input logic signed [67:0] x, input int w);
      if (w == 32) return {{32{x[31]}}, x[31:0]};
      return x[63:0];
   endfunction

   function automatic void refModel(input logic s, input logic i64, input logic p1, input logic neg,
                                    input logic is_nan, input logic ovf, input logic [63:0] m,
                                    output logic [63:0] r, output logic inv);
      logic signed [67:0] u, v, lo, hi, one;
      logic ok;
      int w;
      w   = i64 ? 64 : 32;
      one = 68'sd1;
      u   = $signed({4'b0, m}) + (p1 ? one : 68'sd0);
      v   = neg ? -u : u;
      if (s) begin
         lo = -(one <<< (w - 1));
         hi = (one <<< (w - 1)) - one;
      end else begin
         lo = 68'sd0;
         hi = (one <<< w) - one;
      end
      ok = !ovf && (v >= lo) && (v <= hi);
      if (is_nan)  r = fitWidth(hi, w);
      else if (ok) r = fitWidth(v, w);
      else if (neg) r = fitWidth(lo, w);
      else r = fitWidth(hi, w);
      inv = is_nan || !ok;
   endfunction

   task automatic applyStimulus(input logic s, input logic i64, input logic p1, input logic neg,
                                input logic is_nan, input logic ovf, input logic [63:0] m,
                                input int stall, input logic [63:0] exp_res, input logic exp_nv);
      int n;
      logic [63:0] held_res;
      logic held_nv;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
      sgn = s; int64 = i64; plus1 = p1; xs = neg; nan = is_nan; mag_ovf = ovf; mag = m;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      // Keep InValid high and scramble operands: nothing may be captured while busy.
      sgn = 1'($urandom); int64 = 1'($urandom); plus1 = 1'($urandom); xs = 1'($urandom);
      nan = 1'($urandom); mag = {$urandom, $urandom};
      n = 0;
      while (!out_valid && n < 8) begin
         checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
         @(negedge clk);
         n++;
      end
      checkOutput("latency", 64'(n), i64 ? 64'd2 : 64'd1);
      checkOutput("res", res, exp_res);
      checkOutput("nv", 64'(nv), 64'(exp_nv));
      held_res = res;
      held_nv  = nv;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         mag = {$urandom, $urandom};
      end
      if (stall > 0) begin
         checkOutput("hold_res", res, held_res);
         checkOutput("hold_nv", 64'(nv), 64'(held_nv));
         checkOutput("hold_valid", 64'(out_valid), 64'd1);
         checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("post_valid", 64'(out_valid), 64'd0);
      checkOutput("post_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] r_exp, m;
      logic nv_exp, s, i64, p1, neg, is_nan, ovf;
      int n;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      sgn = 1'b0; int64 = 1'b0; plus1 = 1'b0; xs = 1'b0; nan = 1'b0; mag_ovf = 1'b0; mag = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_res", res, 64'd0);
      checkOutput("reset_nv", 64'(nv), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(1, 0, 1, 1, 0, 0, 64'h0000_0000_7FFF_FFFF, 0, 64'hFFFF_FFFF_8000_0000, 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 64'h0000_0000_7FFF_FFFF, 0, 64'h0000_0000_7FFF_FFFF, 1);
      applyStimulus(0, 1, 0, 1, 0, 0, 64'h0, 0, 64'h0, 0);
      applyStimulus(0, 1, 1, 1, 0, 0, 64'h0, 0, 64'h0, 1);
      applyStimulus(0, 1, 1, 0, 0, 0, 64'h0000_0000_FFFF_FFFF, 0, 64'h0000_0001_0000_0000, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      applyStimulus(1, 1, 0, 1, 1, 0, 64'h0000_1234_5678_9ABC, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 64'h0000_0000_FFFF_FFFF, 5, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0000_0001_0000_0000, 0, 64'h0000_0000_7FFF_FFFF, 1);
      applyStimulus(1, 1, 0, 1, 0, 1, 64'h0, 0, 64'h8000_0000_0000_0000, 1);

      for (int k = 0; k < 200; k++) begin
         s = 1'($urandom); i64 = 1'($urandom); p1 = 1'($urandom); neg = 1'($urandom);
         is_nan = ($urandom_range(0, 15) == 0);
         ovf    = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 7))
            0:       m = {$urandom, $urandom};
            1:       m = {32'h0, $urandom};
            2:       m = 64'h0000_0000_7FFF_FFFF;
            3:       m = 64'h0000_0000_FFFF_FFFF;
            4:       m = 64'h7FFF_FFFF_FFFF_FFFF;
            5:       m = 64'hFFFF_FFFF_FFFF_FFFF;
            6:       m = 64'h0000_0000_8000_0000;
            default: m = {60'h0, 4'($urandom)};
         endcase
         refModel(s, i64, p1, neg, is_nan, ovf, m, r_exp, nv_exp);
         applyStimulus(s, i64, p1, neg, is_nan, ovf, m, $urandom_range(0, 2), r_exp, nv_exp);
      end

      // Flush while the high half is being added: the operation must vanish.
      sgn = 1'b0; int64 = 1'b1; plus1 = 1'b1; xs = 1'b0; nan = 1'b0; mag_ovf = 1'b0;
      mag = 64'h0000_0000_FFFF_FFFF;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
      checkOutput("flush_valid", 64'(out_valid), 64'd0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      checkOutput("flush_never_valid", 64'(n), 64'd0);
      applyStimulus(1, 1, 1, 1, 0, 0, 64'h0000_0000_0000_0041, 0, 64'hFFFF_FFFF_FFFF_FFBE, 0);

      // Reset while a result is waiting in DONE.
      sgn = 1'b1; int64 = 1'b0; plus1 = 1'b0; xs = 1'b1; nan = 1'b0; mag_ovf = 1'b0;
      mag = 64'h0000_0000_0000_0005;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      checkOutput("pre_reset_res", res, 64'hFFFF_FFFF_FFFF_FFFB);
      reset = 1'b1;
      #1;
      checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
      checkOutput("async_reset_res", res, 64'd0);
      checkOutput("async_reset_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_valid", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule

// File: doc/cvt_int_seq.md
# cvt_int_seq

- Multi-cycle sequencer for the final step of float-to-integer conversion (fcvt.w/wu/l/lu).
- Takes the normalized integer magnitude, sign and rounding increment, and produces the rounded, possibly negated, saturated XLEN result plus the invalid flag.
- Reuses one 32-bit adder slice over one or two passes instead of a full-width XLEN+2 adder.
- Sits between the FPU normalization shifter/rounder and the FPU result mux; connected by valid/ready handshakes.

## Interface

Parameters:
- XLEN, default 64, result width; 32 or 64.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- InValid  input  1  request valid.
- InReady  output  1  block can accept a request; high only in IDLE.
- Signed  input  1  signed target (w/l).
- Int64  input  1  64-bit target (l/lu); ignored and treated as 0 when XLEN=32.
- Plus1  input  1  add one for rounding.
- Xs  input  1  source sign.
- NaN  input  1  source is NaN.
- MagOvf  input  1  magnitude ≥ 2^XLEN (already out of range).
- Mag  input  XLEN  truncated integer magnitude.
- Flush  input  1  synchronous abort.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts result.
- Res  output  XLEN  integer result.
- NV  output  1  invalid-operation flag.

## Operation

- State machine: IDLE, LO, HI, DONE.
- Operand capture:
  - In IDLE, when InValid & InReady, capture all inputs; next state LO.
  - Inputs are ignored in every other state.
- Adder datapath: one adder computes (Mag ^ {XLEN{Xs}}) + (Plus1 ^ Xs).
  - This equals Mag+Plus1 when Xs=0, and −(Mag+Plus1) when Xs=1.
- LO:
  - Add bits [31:0] with carry-in Plus1^Xs.
  - Register the sum and the carry-out.
  - If W=32 (Int64=0 or XLEN=32), next state DONE; otherwise next state HI.
- HI:
  - Add bits [63:32] with the stored carry.
  - Next state DONE.
- Range check:
  - Let W be the target width.
  - Let U = Mag+Plus1, the (XLEN+1)-bit magnitude, with MagOvf treated as U ≥ 2^XLEN.
  - Let V = Xs ? −U : U.
  - Signed targets: in range iff −2^(W−1) ≤ V ≤ 2^(W−1)−1.
  - Unsigned targets: in range iff 0 ≤ V ≤ 2^W−1.
  - The decision uses the final carry and the high sum bits. No extra adder pass is allowed.
- Result selection:
  - In range: Res = V truncated to W bits; NV=0.
  - NaN, or out of range with Xs=0: saturate to max (signed 2^(W−1)−1, unsigned 2^W−1); NV=1.
  - Out of range with Xs=1: saturate to min (signed −2^(W−1), unsigned 0); NV=1.
  - A negative value that rounds to zero (Xs=1, U=0) is in range: Res=0, NV=0.
- Sign extension: when W=32 and XLEN=64, Res is bit 31 sign-extended to 64 bits. This applies to unsigned wu too, per RISC-V.
- DONE:
  - OutValid=1; Res and NV held stable.
  - When OutReady=1, the transfer occurs; next state IDLE.
- Flush:
  - In any state, Flush forces next state IDLE and drops OutValid next cycle.
  - Flush takes priority over accept and over OutReady.
  - No handshake completes in a cycle with Flush=1.

## Timing

- Reset values:
  - state IDLE; InReady=1; OutValid=0; Res=0; NV=0; carry register 0.
  - Any state, including mid-conversion, is abandoned asynchronously.
  - No output transfer occurs for the interrupted operation.
- Latency, with the accept edge counted as edge 0:
  - W=32: OutValid high after edge 1.
  - W=64: OutValid high after edge 2.
- Throughput:
  - One request per 3 cycles (W=32) or 4 cycles (W=64) when OutReady is held high.
  - No overlap: InReady stays low from the accept edge until the cycle after the output transfer.
- InReady and OutValid are purely state-decoded. There are no combinational paths from InValid or OutReady.
- Backpressure: Res/NV remain constant while OutValid=1 and OutReady=0, for an unbounded time.

## Test plan

- Signed 32, negative minimum: XLEN=64, Int64=0, Signed=1, Xs=1, Mag=0x7FFFFFFF, Plus1=1 -> after 1 cycle, Res=0xFFFFFFFF80000000, NV=0.
- Signed 32, positive overflow: Int64=0, Signed=1, Xs=0, Mag=0x7FFFFFFF, Plus1=1 -> Res=0x000000007FFFFFFF, NV=1.
- Unsigned negative cases, Int64=1, Signed=0, Xs=1, Mag=0:
  - Plus1=0 -> Res=0, NV=0.
  - Plus1=1 -> Res=0, NV=1.
- 64-bit carry across halves, Int64=1, Signed=0:
  - Mag=0x00000000FFFFFFFF, Plus1=1 -> Res=0x0000000100000000, NV=0, OutValid 2 cycles after accept.
  - Mag=all ones, Plus1=1 -> Res=all ones, NV=1.
- NaN and wu max:
  - NaN=1, Signed=1, Int64=1 -> Res=0x7FFFFFFFFFFFFFFF, NV=1.
  - Unsigned 32, Xs=0, Mag=0xFFFFFFFF, Plus1=0 -> Res=0xFFFFFFFFFFFFFFFF, NV=0.
- Handshake and abort:
  - Hold OutReady=0 for 5 cycles: Res stable; InReady=0 with InValid held high.
  - Flush asserted in HI: IDLE next cycle; OutValid never rises.
  - Reset asserted in DONE: OutValid=0 immediately.
